// File: rtl/cpu_mon_pkg.sv
// cpu_mon_pkg: shared types and constants for the CPU run-control / display monitor.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package cpu_mon_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } mon_state_t;

    // run_mode encodings
    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_FREE = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    // disp_sel encodings
    localparam logic [1:0] DISP_PC     = 2'd0;
    localparam logic [1:0] DISP_WB     = 2'd1;
    localparam logic [1:0] DISP_RETIRE = 2'd2;
    localparam logic [1:0] DISP_BP     = 2'd3;

    // Active-low seven-segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b100_0000;
            4'h1:    s = 7'b111_1001;
            4'h2:    s = 7'b010_0100;
            4'h3:    s = 7'b011_0000;
            4'h4:    s = 7'b001_1001;
            4'h5:    s = 7'b001_0010;
            4'h6:    s = 7'b000_0010;
            4'h7:    s = 7'b111_1000;
            4'h8:    s = 7'b000_0000;
            4'h9:    s = 7'b001_0000;
            4'hA:    s = 7'b000_1000;
            4'hB:    s = 7'b000_0011;
            4'hC:    s = 7'b100_0110;
            4'hD:    s = 7'b010_0001;
            4'hE:    s = 7'b000_0110;
            default: s = 7'b000_1110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mon_step_sync.sv
// mon_step_sync: two-flop synchroniser plus rising-edge detector for the raw step button.
// Latency: pulse is high during the cycle after the 3rd clock edge following the button edge.
// Backpressure: none; a held button yields a single one-clock pulse.
module mon_step_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the previous synchronised level
    logic [2:0] sync_q;

    // Shift the button through the synchroniser and register the rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], btn};
            pulse  <= sync_q[1] & ~sync_q[2];
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: processor run control (halt/free/fast/step), PC breakpoint, retire counter, hex display.
// Latency: cpu_en/bp_hit decoded from state in-cycle; step button 3 clk to step_pulse; seg registered, 1 clk.
// Backpressure: none; the core advances only on cpu_en. Build option CPU_MON_LZ_BLANK_EN blanks leading zeros.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int DIV_MAX = 12_499_999,
    parameter int DIV_W   = 24,
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int DIGITS  = 6,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            run_mode,
    input  logic                  step_btn,
    input  logic                  bp_en,
    input  logic [PC_W-1:0]       bp_addr,
    input  logic [PC_W-1:0]       pc,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  wb_valid,
    input  logic [1:0]            disp_sel,
    output logic                  cpu_en,
    output logic                  halted,
    output logic                  bp_hit,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic [DIGITS*7-1:0]   seg
);

    localparam int VW    = DIGITS * 4;
    localparam int W_A   = (PC_W > DATA_W) ? PC_W : DATA_W;
    localparam int W_B   = (W_A > CNT_W) ? W_A : CNT_W;
    localparam int WIDE  = (W_B > VW) ? W_B : VW;
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(DIV_MAX);

    mon_state_t          state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic                div_wrap;
    logic                run_cand;
    logic                bp_match;
    logic                step_pulse;
    logic [DATA_W-1:0]   wb_latch;
    logic [WIDE-1:0]     sel_wide;
    logic [VW-1:0]       disp_val;
    logic [3:0]          nib;
    logic [DIGITS*7-1:0] seg_nxt;
    logic                disp_unused;

    mon_step_sync u_step_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   (step_btn),
        .pulse (step_pulse)
    );

    // State register; reset parks the monitor in HALT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the per-cycle cpu_en / bp_hit decode
    always_comb begin
        state_nxt = state;
        cpu_en    = 1'b0;
        bp_hit    = 1'b0;
        div_wrap  = (div_cnt == DIV_TOP);
        bp_match  = bp_en && (pc == bp_addr);
        run_cand  = (run_mode == MODE_FAST) || ((run_mode == MODE_FREE) && div_wrap);
        if (run_mode == MODE_HALT) begin
            state_nxt = ST_HALT;
        end else begin
            case (state)
                ST_HALT: begin
                    state_nxt = (run_mode == MODE_STEP) ? ST_STEP : ST_RUN;
                end
                ST_RUN: begin
                    if (run_cand && bp_match) begin
                        // Stop before executing the breakpoint instruction
                        bp_hit    = 1'b1;
                        state_nxt = ST_BREAK;
                    end else begin
                        cpu_en = run_cand;
                        if (run_mode == MODE_STEP) begin
                            state_nxt = ST_STEP;
                        end
                    end
                end
                ST_STEP: begin
                    cpu_en = step_pulse;
                    if (run_mode != MODE_STEP) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    // BREAK: a step executes the breakpoint instruction once, unmasked
                    if (step_pulse) begin
                        cpu_en    = 1'b1;
                        state_nxt = (run_mode == MODE_STEP) ? ST_STEP : ST_RUN;
                    end else if (run_mode == MODE_STEP) begin
                        state_nxt = ST_STEP;
                    end else if (!bp_en) begin
                        state_nxt = ST_RUN;
                    end
                end
            endcase
        end
    end

    assign halted = (state == ST_HALT) || (state == ST_BREAK);

    // Free-run divider: only counts while running in divided mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if ((state == ST_RUN) && (run_mode == MODE_FREE)) begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
        end else begin
            div_cnt <= '0;
        end
    end

    // Retire counter and write-back capture on each enabled processor cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
            wb_latch   <= '0;
        end else if (cpu_en) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
            if (wb_valid) begin
                wb_latch <= wb_data;
            end
        end
    end

    // Display source select, zero-extended to a common width then cut to the digit count
    always_comb begin
        sel_wide = '0;
        case (disp_sel)
            DISP_PC:     sel_wide[PC_W-1:0]   = pc;
            DISP_WB:     sel_wide[DATA_W-1:0] = wb_latch;
            DISP_RETIRE: sel_wide[CNT_W-1:0]  = retire_cnt;
            default:     sel_wide[PC_W-1:0]   = bp_addr;
        endcase
    end

    assign disp_val    = sel_wide[VW-1:0];
    // Bits above the displayed digits are intentionally dropped
    assign disp_unused = ^sel_wide;

`ifdef CPU_MON_LZ_BLANK_EN
    logic seen_nz;

    // Hex decode with leading-zero blanking, scanning from the top digit down
    always_comb begin
        seg_nxt = '1;
        seen_nz = 1'b0;
        nib     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib     = disp_val[i*4 +: 4];
            seen_nz = seen_nz | (nib != 4'h0);
            if (seen_nz || (i == 0)) begin
                seg_nxt[i*7 +: 7] = hex_to_seg(nib);
            end
        end
    end
`else
    // Hex decode of every digit, leading zeros included
    always_comb begin
        seg_nxt = '1;
        nib     = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib               = disp_val[i*4 +: 4];
            seg_nxt[i*7 +: 7] = hex_to_seg(nib);
        end
    end
`endif

    // Registered segment drive; reset shows all segments off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= '1;
        end else begin
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed and randomized checks of cpu_run_monitor against a behavioural model.
// Latency: model predicts in-cycle cpu_en/bp_hit/halted and 1-clock registered seg.
// Backpressure: n/a.
module tb_cpu_run_monitor;

    localparam int DIV_MAX = 3;
    localparam int DIV_W   = 4;
    localparam int PC_W    = 32;
    localparam int DATA_W  = 32;
    localparam int DIGITS  = 6;
    localparam int CNT_W   = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            run_mode;
    logic                  step_btn;
    logic                  bp_en;
    logic [PC_W-1:0]       bp_addr;
    logic [PC_W-1:0]       pc;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_valid;
    logic [1:0]            disp_sel;
    logic                  cpu_en;
    logic                  halted;
    logic                  bp_hit;
    logic [CNT_W-1:0]      retire_cnt;
    logic [DIGITS*7-1:0]   seg;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .DIV_MAX (DIV_MAX),
        .DIV_W   (DIV_W),
        .PC_W    (PC_W),
        .DATA_W  (DATA_W),
        .DIGITS  (DIGITS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_mode   (run_mode),
        .step_btn   (step_btn),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .wb_data    (wb_data),
        .wb_valid   (wb_valid),
        .disp_sel   (disp_sel),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .retire_cnt (retire_cnt),
        .seg        (seg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Standard active-high segment codes (bit 0 = a ... bit 6 = g)
    function automatic logic [6:0] lit_segs(input logic [3:0] d);
        case (d)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // What the display should show for a 24-bit value
    function automatic logic [41:0] seg_image(input logic [23:0] v);
        logic [41:0] img;
        int nd;
        nd = DIGITS;
`ifdef CPU_MON_LZ_BLANK_EN
        nd = 1;
        for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] != 4'h0) nd = i + 1;
`endif
        img = '1;
        for (int i = 0; i < nd; i++) img[i*7 +: 7] = ~lit_segs(v[i*4 +: 4]);
        return img;
    endfunction

    // Behavioural model: 0 idle-halted, 1 running, 2 single-stepping, 3 parked at breakpoint
    int          m_st;
    longint      m_run_clks;
    logic [3:0]  m_btn_hist;
    int          m_ret;
    logic [31:0] m_wb;
    logic [41:0] m_seg;
    bit          m_en;
    bit          obs_en;
    int          dut_en_total = 0;
    int          dut_hit_total = 0;

    task automatic check_reset(input string pfx);
        check_val({pfx, "_cpu_en"}, 64'(cpu_en), 64'd0);
        check_val({pfx, "_bp_hit"}, 64'(bp_hit), 64'd0);
        check_val({pfx, "_halted"}, 64'(halted), 64'd1);
        check_val({pfx, "_retire"}, 64'(retire_cnt), 64'd0);
        check_val({pfx, "_seg"}, 64'(seg), {22'd0, 42'h3FF_FFFF_FFFF});
    endtask

    // One clock: check in-cycle outputs, advance model, cross posedge, return at negedge
    task automatic tick();
        bit pulse, match, cand, hit;
        int nxt;
        logic [23:0] v;
        #1;
        obs_en = cpu_en;
        if (cpu_en) dut_en_total++;
        if (bp_hit) dut_hit_total++;
        if (rst) begin
            check_reset("rst");
            m_st = 0; m_run_clks = 0; m_btn_hist = '0; m_ret = 0; m_wb = '0;
            m_seg = '1; m_en = 0;
        end else begin
            pulse = m_btn_hist[2] & ~m_btn_hist[3];
            match = bp_en && (pc == bp_addr);
            m_en = 0; hit = 0; nxt = m_st;
            if (run_mode == 2'b00) nxt = 0;
            else if (m_st == 0) nxt = (run_mode == 2'b10) ? 2 : 1;
            else if (m_st == 1) begin
                cand = (run_mode == 2'b11) ||
                       (run_mode == 2'b01 && (m_run_clks % (DIV_MAX + 1)) == DIV_MAX);
                if (cand && match) begin hit = 1; nxt = 3; end
                else begin m_en = cand; nxt = (run_mode == 2'b10) ? 2 : 1; end
            end else if (m_st == 2) begin
                m_en = pulse;
                nxt = (run_mode == 2'b10) ? 2 : 1;
            end else begin
                if (pulse) begin m_en = 1; nxt = (run_mode == 2'b10) ? 2 : 1; end
                else if (run_mode == 2'b10) nxt = 2;
                else if (!bp_en) nxt = 1;
            end
            check_val("cpu_en", 64'(cpu_en), 64'(m_en));
            check_val("bp_hit", 64'(bp_hit), 64'(hit));
            check_val("halted", 64'(halted), 64'(m_st == 0 || m_st == 3));
            check_val("retire_cnt", 64'(retire_cnt), 64'(m_ret));
            check_val("seg", 64'(seg), 64'(m_seg));
            case (disp_sel)
                2'd0:    v = pc[23:0];
                2'd1:    v = m_wb[23:0];
                2'd2:    v = 24'(m_ret);
                default: v = bp_addr[23:0];
            endcase
            m_seg = seg_image(v);
            if (m_en) begin
                m_ret = (m_ret + 1) % (1 << CNT_W);
                if (wb_valid) m_wb = wb_data;
            end
            if (m_st == 1 && run_mode == 2'b01) m_run_clks++;
            else m_run_clks = 0;
            m_btn_hist = {m_btn_hist[2:0], step_btn};
            m_st = nxt;
        end
        @(posedge clk);
        @(negedge clk);
        if (m_en) pc = pc + 32'd4;
    endtask

    int base, first_idx, cnt_win;
    logic [41:0] exp_img;

    initial begin
        rst = 1'b1; run_mode = 2'b11; step_btn = 1'b0; bp_en = 1'b0; bp_addr = '0;
        pc = '0; wb_data = '0; wb_valid = 1'b0; disp_sel = 2'd0;
        m_st = 0; m_run_clks = 0; m_btn_hist = '0; m_ret = 0; m_wb = '0; m_seg = '1; m_en = 0;
        @(negedge clk);
        repeat (3) tick();

        // Fast mode: one HALT cycle, then cpu_en every clock
        rst = 1'b0;
        base = dut_en_total;
        repeat (11) tick();
        check_val("fast_pulse_count", 64'(dut_en_total - base), 64'd10);
        check_val("fast_retire_10", 64'(retire_cnt), 64'd10);

        // Divided mode: one pulse per DIV_MAX+1 clocks, then halt
        run_mode = 2'b01;
        base = dut_en_total;
        repeat (20) tick();
        check_val("free_pulse_count", 64'(dut_en_total - base), 64'd5);
        run_mode = 2'b00;
        tick();
        check_val("halt_within_1", 64'(halted), 64'd1);

        // Breakpoint at 0x10 in fast mode, then one step past it
        pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h10; run_mode = 2'b11;
        base = dut_hit_total;
        repeat (10) tick();
        check_val("bp_hit_once", 64'(dut_hit_total - base), 64'd1);
        check_val("bp_parked", 64'(halted), 64'd1);
        step_btn = 1'b1;
        first_idx = -1; cnt_win = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (obs_en && first_idx < 0) first_idx = k;
            if (obs_en && k <= 3) cnt_win++;
        end
        check_val("bp_step_latency", 64'(first_idx), 64'd3);
        check_val("bp_step_single", 64'(cnt_win), 64'd1);
        check_val("bp_resumed_run", 64'(halted), 64'd0);
        step_btn = 1'b0;

        // Second breakpoint, released by clearing bp_en
        run_mode = 2'b00;
        tick();
        pc = 32'h8; run_mode = 2'b11;
        repeat (6) tick();
        bp_en = 1'b0;
        repeat (3) tick();

        // Single step: three presses, each held, give three pulses
        run_mode = 2'b10;
        tick();
        base = dut_en_total;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            repeat (6) tick();
            step_btn = 1'b0;
            repeat (4) tick();
        end
        check_val("step_three_presses", 64'(dut_en_total - base), 64'd3);

        // Write-back capture and hold on the display
        run_mode = 2'b11;
        tick();
        disp_sel = 2'd1; wb_valid = 1'b1; wb_data = 32'h00AB_CDEF;
        tick();
        wb_valid = 1'b0; wb_data = $urandom;
        tick();
        exp_img = {~lit_segs(4'hA), ~lit_segs(4'hB), ~lit_segs(4'hC),
                   ~lit_segs(4'hD), ~lit_segs(4'hE), ~lit_segs(4'hF)};
        check_val("wb_display", 64'(seg), 64'(exp_img));
        repeat (3) begin wb_data = $urandom; tick(); end
        check_val("wb_hold", 64'(seg), 64'(exp_img));

        // Retire count 0x1F on the display
        rst = 1'b1;
        tick();
        rst = 1'b0; run_mode = 2'b11; disp_sel = 2'd2; bp_en = 1'b0;
        repeat (32) tick();
        run_mode = 2'b00;
        tick();
        tick();
        exp_img[6:0]  = ~lit_segs(4'hF);
        exp_img[13:7] = ~lit_segs(4'h1);
`ifdef CPU_MON_LZ_BLANK_EN
        exp_img[41:14] = '1;
`else
        for (int i = 2; i < DIGITS; i++) exp_img[i*7 +: 7] = ~lit_segs(4'h0);
`endif
        check_val("retire_1f_display", 64'(seg), 64'(exp_img));

        // Long fast run so the retire counter wraps
        run_mode = 2'b11;
        repeat (270) tick();

        // Asynchronous reset in the middle of a cycle
        #2;
        rst = 1'b1;
        #1;
        check_reset("async");
        tick();
        rst = 1'b0;

        // Randomized operation
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) run_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 31) == 0) bp_en = ~bp_en;
            if ($urandom_range(0, 19) == 0) bp_addr = pc + 32'(4 * $urandom_range(0, 4));
            wb_valid = 1'($urandom_range(0, 1));
            wb_data  = $urandom;
            if ($urandom_range(0, 7) == 0) disp_sel = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
